// File: rtl/mat_acc_sequencer.sv
// rtl/mat_acc_sequencer.sv - stream loader/drainer around the multiply_long matrix accelerator
//
// Purpose: accepts mat_A then mat_B as a 32-bit valid/ready stream into operand
// register arrays, raises start to the multiplier, waits for done (with an optional
// watchdog), then streams mat_C back out word by word. One job in flight at a time.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input stream handshake, in_data = 4 x 8-bit lanes
//   mat_A_o, mat_B_o      operand arrays held for the multiplier
//   start_o, done_i       level start out, completion in
//   mat_C_i               result array, held by the multiplier until drained
//   out_valid/out_ready   output stream handshake, out_data = mat_C_i[idx]
//   busy_o                low only when idle in LOAD_A with no word loaded
//   err_o                 sticky watchdog timeout flag
module mat_acc_sequencer #(
  parameter int WORDS   = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  output logic [3:0][7:0] mat_A_o [WORDS],
  output logic [3:0][7:0] mat_B_o [WORDS],
  output logic            start_o,
  input  logic            done_i,
  input  logic [3:0][7:0] mat_C_i [WORDS],
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic            busy_o,
  output logic            err_o
);

  localparam int            IW         = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int            WW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(WORDS - 1);
  localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT - 1);
  localparam logic          WDOG_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_LOAD_A, S_LOAD_B, S_RUN, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_idx;
  logic [WW-1:0]   r_wdog;
  logic            r_armed;
  logic            r_err;
  logic            r_start;
  logic            r_out_valid;
  logic [3:0][7:0] r_mat_a [WORDS];
  logic [3:0][7:0] r_mat_b [WORDS];

  logic w_in_fire;
  logic w_out_fire;
  logic w_last;
  logic w_done_take;
  logic w_timeout;
  logic w_run_exit;

  // in_ready is a pure state decode so it never depends on in_valid.
  assign in_ready   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign start_o    = r_start;
  assign out_valid  = r_out_valid;
  assign out_data   = mat_C_i[r_idx];
  assign busy_o     = !((r_state == S_LOAD_A) && (r_idx == '0));
  assign err_o      = r_err;
  assign mat_A_o    = r_mat_a;
  assign mat_B_o    = r_mat_b;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_last     = (r_idx == LAST_IDX);

  // r_armed is low during the first RUN cycle, so a done left over from a
  // previous job (or held high early) cannot end this one immediately.
  assign w_done_take = (r_state == S_RUN) && r_armed && done_i;
  assign w_timeout   = (r_state == S_RUN) && !w_done_take && WDOG_EN && (r_wdog == WDOG_LIMIT);
  assign w_run_exit  = w_done_take || w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD_A;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD_A: if (w_in_fire && w_last)  w_next = S_LOAD_B;
      S_LOAD_B: if (w_in_fire && w_last)  w_next = S_RUN;
      S_RUN:    if (w_run_exit)           w_next = S_DRAIN;
      S_DRAIN:  if (w_out_fire && w_last) w_next = S_LOAD_A;
      default:                            w_next = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_wdog      <= '0;
      r_armed     <= 1'b0;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // start/out_valid registered from the next state: glitch-free levels.
      r_start     <= (w_next == S_RUN);
      r_out_valid <= (w_next == S_DRAIN);
      r_armed     <= (r_state == S_RUN);
      // Watchdog sits at zero outside RUN, so it always starts a job from 0.
      r_wdog      <= (r_state == S_RUN) ? r_wdog + 1'b1 : '0;
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_in_fire || w_out_fire) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end else if (w_run_exit) begin
        r_idx <= '0;
      end
    end
  end

  // Operand arrays only change on an accepted input word, so they stay put
  // through RUN and DRAIN until the next job starts overwriting mat_A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        r_mat_a[i] <= '0;
        r_mat_b[i] <= '0;
      end
    end else if (w_in_fire) begin
      if (r_state == S_LOAD_A) begin
        r_mat_a[r_idx] <= in_data;
      end else begin
        r_mat_b[r_idx] <= in_data;
      end
    end
  end

endmodule
